// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader:
// FSM states, field sizes and the state-to-ready decode.
package imem_loader_pkg;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned HDR_BYTES      = 4;
    localparam int unsigned WORD_W         = 8 * BYTES_PER_WORD;

    typedef enum logic [2:0] {
        ST_HDR   = 3'd0,
        ST_DATA  = 3'd1,
        ST_WRITE = 3'd2,
        ST_CSUM  = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERROR = 3'd5
    } state_t;

    // ERROR keeps accepting so an upstream sender can drain the rest of a bad frame.
    function automatic logic state_accepts_bytes(input state_t s);
        return (s == ST_HDR) || (s == ST_DATA) || (s == ST_CSUM) || (s == ST_ERROR);
    endfunction

endpackage

// File: rtl/imem_loader_byte_assembler.sv
// Packs accepted stream bytes into little-endian words; flags the byte that
// completes a word so the caller can act on it in the same cycle.
module byte_assembler
    import imem_loader_pkg::*;
(
    input  logic              i_Clock,
    input  logic              i_Reset,
    input  logic              i_Accept,
    input  logic [7:0]        i_Byte,
    output logic [WORD_W-1:0] o_Word,
    output logic              o_Word_Valid
);

    localparam int unsigned CNT_W = $clog2(BYTES_PER_WORD);

    logic [CNT_W-1:0]  r_Count;
    logic [WORD_W-1:0] r_Shift;
    logic              w_Last;

    assign w_Last = (r_Count == CNT_W'(BYTES_PER_WORD - 1));

    always_ff @(posedge i_Clock) begin
        if (!i_Reset) begin
            r_Count <= '0;
            r_Shift <= '0;
        end else if (i_Accept) begin
            r_Shift <= {i_Byte, r_Shift[WORD_W-1:8]};
            r_Count <= w_Last ? '0 : r_Count + CNT_W'(1);
        end
    end

    // Newest byte lands on top, so the completing byte is the most significant.
    assign o_Word       = {i_Byte, r_Shift[WORD_W-1:8]};
    assign o_Word_Valid = i_Accept && w_Last;

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction memory writer: parses a count/payload/checksum byte
// frame, writes words sequentially and releases the core once the load verifies.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH  = 64,
    parameter int unsigned           DEPTH_WORDS = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0
) (
    input  logic                  i_Clock,
    input  logic                  i_Reset,
    input  logic                  i_Byte_Valid,
    input  logic [7:0]            i_Byte,
    output logic                  o_Byte_Ready,
    output logic                  o_Wr_En,
    output logic [ADDR_WIDTH-1:0] o_Wr_Addr,
    output logic [31:0]           o_Wr_Data,
    input  logic                  i_Wr_Ready,
    output logic                  o_Core_Reset,
    output logic                  o_Done,
    output logic                  o_Error
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS + 1);
    localparam int unsigned HDR_W = 8 * HDR_BYTES;

    state_t                r_State;
    logic [IDX_W-1:0]      r_Index;
    logic [IDX_W-1:0]      r_Num;
    logic [WORD_W-1:0]     r_Csum;
    logic                  r_Wr_En;
    logic [ADDR_WIDTH-1:0] r_Wr_Addr;
    logic [31:0]           r_Wr_Data;
    logic                  r_Core_Reset;
    logic                  r_Done;
    logic                  r_Error;

    logic                  w_Ready;
    logic                  w_Accept;
    logic [WORD_W-1:0]     w_Word;
    logic                  w_Word_Valid;
    logic [HDR_W-1:0]      w_Hdr_N;
    logic                  w_Oversize;
    logic [IDX_W-1:0]      w_Index_Next;

    assign w_Ready      = i_Reset && state_accepts_bytes(r_State);
    assign w_Accept     = i_Byte_Valid && w_Ready;
    assign w_Hdr_N      = w_Word[HDR_W-1:0];
    assign w_Oversize   = (w_Hdr_N > HDR_W'(DEPTH_WORDS));
    assign w_Index_Next = r_Index + IDX_W'(1);

    byte_assembler u_byte_assembler (
        .i_Clock      (i_Clock),
        .i_Reset      (i_Reset),
        .i_Accept     (w_Accept),
        .i_Byte       (i_Byte),
        .o_Word       (w_Word),
        .o_Word_Valid (w_Word_Valid)
    );

    always_ff @(posedge i_Clock) begin
        if (!i_Reset) begin
            r_State      <= ST_HDR;
            r_Index      <= '0;
            r_Num        <= '0;
            r_Csum       <= '0;
            r_Wr_En      <= 1'b0;
            r_Wr_Addr    <= BASE_ADDR;
            r_Wr_Data    <= '0;
            r_Core_Reset <= 1'b1;
            r_Done       <= 1'b0;
            r_Error      <= 1'b0;
        end else begin
            case (r_State)
                ST_HDR: begin
                    if (w_Word_Valid) begin
                        // Truncation is safe: oversize counts never reach DATA.
                        r_Num <= w_Hdr_N[IDX_W-1:0];
                        if (w_Oversize) begin
                            r_State <= ST_ERROR;
                            r_Error <= 1'b1;
                        end else if (w_Hdr_N == '0) begin
                            r_State <= ST_CSUM;
                        end else begin
                            r_State <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_Word_Valid) begin
                        r_Wr_Data <= w_Word;
                        r_Csum    <= r_Csum ^ w_Word;
                        r_Wr_En   <= 1'b1;
                        r_State   <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (i_Wr_Ready) begin
                        r_Wr_En   <= 1'b0;
                        r_Index   <= w_Index_Next;
                        // Incremental form of BASE_ADDR + (index << 2).
                        r_Wr_Addr <= r_Wr_Addr + ADDR_WIDTH'(BYTES_PER_WORD);
                        r_State   <= (w_Index_Next == r_Num) ? ST_CSUM : ST_DATA;
                    end
                end
                ST_CSUM: begin
                    if (w_Word_Valid) begin
                        if (w_Word == r_Csum) begin
                            r_State      <= ST_DONE;
                            r_Done       <= 1'b1;
                            r_Core_Reset <= 1'b0;
                        end else begin
                            r_State <= ST_ERROR;
                            r_Error <= 1'b1;
                        end
                    end
                end
                ST_DONE, ST_ERROR: begin
                    r_State <= r_State;
                end
                default: begin
                    r_State <= ST_ERROR;
                    r_Wr_En <= 1'b0;
                    r_Error <= 1'b1;
                end
            endcase
        end
    end

    assign o_Byte_Ready = w_Ready;
    assign o_Wr_En      = r_Wr_En;
    assign o_Wr_Addr    = r_Wr_Addr;
    assign o_Wr_Data    = r_Wr_Data;
    assign o_Core_Reset = r_Core_Reset;
    assign o_Done       = r_Done;
    assign o_Error      = r_Error;

endmodule
